score_display_driver: RTL
=========================

Name: score_display_driver

Overview:
- Upstream feeder for the 4-digit BCD-to-7-segment decoder stage in the game console.
- Accepts a binary score value and converts it to four BCD digits sequentially using shift-add-3 (double dabble).
- Time-multiplexes the four digits onto one 4-bit nibble bus (DIGIT) that drives the decoder input, plus active-low anode enables.
- Optionally blanks leading zeros.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit slot is held before the scan advances (1 kHz per digit at 50 MHz). Must be ≥2.
- BIN_W, 14: width of the binary input value.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- VALUE  in  BIN_W  binary score to display.
- LOAD  in  1  request to convert VALUE; sampled only while BUSY=0.
- BLANK_LZ  in  1  1 = blank leading zero digits; sampled live.
- BUSY  out  1  high while a conversion is in progress.
- OVF  out  1  high when the last loaded VALUE exceeded 9999.
- DIGIT  out  4  BCD nibble of the current scan slot; feeds the decoder IN.
- AN  out  4  active-low one-hot anode enable; AN[i] selects digit i (0 = ones).

Behaviour:
- Reset (RST_N=0, asynchronous):
  - FSM returns to IDLE.
  - BUSY=0, OVF=0.
  - Display BCD registers = 0000.
  - Scan counter = 0; slot index = 0.
  - Outputs: AN=1110, DIGIT=0000.
  - Reset mid-conversion discards the conversion; the display shows 0000.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: if LOAD=1 at an edge:
    - Capture min(VALUE, 9999) into the shift register.
    - Set OVF=(VALUE>9999).
    - Clear the BCD accumulator and the shift count.
    - Go to CONV; BUSY=1 from that edge.
  - CONV: each cycle, add 3 to every accumulator nibble ≥5, then shift {acc, bin} left by 1. After BIN_W shifts, go to COMMIT.
  - COMMIT: copy the accumulator into the display registers in one edge (atomic; no partial values shown), then return to IDLE; BUSY=0 from that edge.
- Latency: LOAD sampled at edge k → BUSY high after edges k … k+BIN_W → display updated and BUSY low after edge k+BIN_W+1 (k+15 at default).
- LOAD while BUSY=1 is ignored; it is not queued.
- LOAD held high continuously restarts a conversion on the first edge after each return to IDLE.
- Scan:
  - Counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the slot index advances 0→1→2→3→0.
- AN and DIGIT are combinational from the registered slot index and the display registers:
  - DIGIT = display nibble[index].
  - AN = ~(1<<index).
- Leading-zero blanking, when BLANK_LZ=1:
  - Slot i>0 is blanked if nibble i and all higher nibbles are zero.
  - A blanked slot drives AN=1111; DIGIT still carries the nibble.
  - Slot 0 is never blanked.
  - Interior zeros, e.g. the tens digit of 1005, are shown.
- Display registers hold their value indefinitely until the next COMMIT.

Test Plan (REFRESH_DIV=4 in simulation):
1. Assert RST_N=0 then release, BLANK_LZ=0 → AN=1110, DIGIT=0, BUSY=0, OVF=0. After 4 clocks AN=1101, after 8 AN=1011, after 12 AN=0111, after 16 AN=1110; DIGIT=0 throughout.
2. Pulse LOAD with VALUE=1234 → BUSY high for exactly 15 cycles. Then slots 0..3 show DIGIT 4,3,2,1 with AN 1110,1101,1011,0111; OVF=0.
3. VALUE=12000, LOAD → OVF=1 and all four digits read 9. Then VALUE=42, LOAD → OVF=0, digits 2,4,0,0.
4. BLANK_LZ=1:
   - VALUE=7 → slot 0 AN=1110 DIGIT=7; slots 1–3 AN=1111.
   - VALUE=1005 → all four slots enabled, digits 5,0,0,1.
   - VALUE=0 → only slot 0 enabled, DIGIT=0.
5. Load 1234, then during BUSY pulse LOAD with VALUE=5678 → ignored; display 1234 after BUSY falls.
6. Start a conversion of 9999, assert RST_N at cycle 5 of CONV → immediate BUSY=0, display 0000, AN=1110. After release, the scan restarts at slot 0.

Source files
------------

// File: rtl/score_display_if.sv
// Bundles the score value/load request and the multiplexed digit outputs
// exchanged between the score source and the display driver.
interface score_display_if #(
  parameter int BIN_W = 14
);
  logic [BIN_W-1:0] value;
  logic             load;
  logic             blank_lz;
  logic             busy;
  logic             ovf;
  logic [3:0]       digit;
  logic [3:0]       an;

  modport master (output value, load, blank_lz, input busy, ovf, digit, an);
  modport slave  (input value, load, blank_lz, output busy, ovf, digit, an);
endinterface

// File: rtl/score_display_driver.sv
// Converts a binary score to four BCD digits (shift-add-3) and time-multiplexes
// them onto one nibble bus with active-low anode enables and zero blanking.
module score_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BIN_W       = 14
) (
  input logic             clk,
  input logic             rst_n,
  score_display_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int SHC_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2} state_t;

  state_t           state_r;
  logic [BIN_W-1:0] bin_r;
  logic [15:0]      acc_r;
  logic [SHC_W-1:0] shcnt_r;
  logic [15:0]      disp_r;
  logic             busy_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;

  logic [31:0]      value_ext_s;
  logic             over_s;
  logic [15:0]      adj_s;
  logic [3:0]       lz_s;

  function automatic logic [3:0] add3(input logic [3:0] n);
    if (n >= 4'd5) begin
      return n + 4'd3;
    end else begin
      return n;
    end
  endfunction

  // Overflow detection and per-nibble add-3 correction ahead of each shift
  always_comb begin
    value_ext_s = 32'(bus.value);
    over_s      = (value_ext_s > 32'd9999);
    adj_s       = {add3(acc_r[15:12]), add3(acc_r[11:8]),
                   add3(acc_r[7:4]),   add3(acc_r[3:0])};
  end

  // Conversion FSM: capture, BIN_W shift-add-3 steps, atomic commit to display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      bin_r   <= '0;
      acc_r   <= 16'd0;
      shcnt_r <= '0;
      disp_r  <= 16'd0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.load) begin
            bin_r   <= over_s ? BIN_W'(32'd9999) : bus.value;
            ovf_r   <= over_s;
            acc_r   <= 16'd0;
            shcnt_r <= '0;
            busy_r  <= 1'b1;
            state_r <= CONV;
          end else begin
            state_r <= IDLE;
          end
        end
        CONV: begin
          acc_r   <= 16'({adj_s, bin_r[BIN_W-1]});
          bin_r   <= bin_r << 1;
          shcnt_r <= shcnt_r + SHC_W'(1);
          if (shcnt_r == SHC_W'(BIN_W - 1)) begin
            state_r <= COMMIT;
          end else begin
            state_r <= CONV;
          end
        end
        COMMIT: begin
          disp_r  <= acc_r;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Free-running refresh divider advancing the scan slot on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else if (cnt_r == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Digit mux and anode decode; a slot is blank when it and all higher nibbles are zero
  always_comb begin
    lz_s[3] = (disp_r[15:12] == 4'd0);
    lz_s[2] = lz_s[3] && (disp_r[11:8] == 4'd0);
    lz_s[1] = lz_s[2] && (disp_r[7:4] == 4'd0);
    lz_s[0] = 1'b0;
    case (idx_r)
      2'd0:    bus.digit = disp_r[3:0];
      2'd1:    bus.digit = disp_r[7:4];
      2'd2:    bus.digit = disp_r[11:8];
      2'd3:    bus.digit = disp_r[15:12];
      default: bus.digit = 4'd0;
    endcase
    if (bus.blank_lz && lz_s[idx_r]) begin
      bus.an = 4'b1111;
    end else begin
      bus.an = ~(4'b0001 << idx_r);
    end
  end

  assign bus.busy = busy_r;
  assign bus.ovf  = ovf_r;

endmodule
